// File: rtl/udp_send_pkg.sv
// Shared constants for the eth_net UDP transmit path: FSM encoding, frame
// field values, header lengths and CRC-32 constants.
package udp_send_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CHECK_SUM = 4'd1,
        ST_PREAMBLE  = 4'd2,
        ST_ETH_HEAD  = 4'd3,
        ST_IP_HEAD   = 4'd4,
        ST_UDP_HEAD  = 4'd5,
        ST_TX_DATA   = 4'd6,
        ST_CRC       = 4'd7,
        ST_IFG       = 4'd8
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_TTL         = 8'h40;

    localparam logic [15:0] CHECK_SUM_LEN  = 16'd4;
    localparam logic [15:0] PREAMBLE_LEN   = 16'd8;
    localparam logic [15:0] ETH_HEAD_LEN   = 16'd14;
    localparam logic [15:0] IP_HEAD_LEN    = 16'd20;
    localparam logic [15:0] UDP_HEAD_LEN   = 16'd8;
    localparam logic [15:0] CRC_LEN        = 16'd4;
    localparam logic [15:0] MAX_PAYLOAD    = 16'd1472;

    localparam logic [31:0] CRC32_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_POLY_REFL = {<<{CRC32_POLY}};
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;

    // Byte idx of a left-aligned header image, MSB byte first.
    function automatic logic [7:0] hdr_byte(input logic [159:0] hdr, input logic [4:0] idx);
        logic [159:0] sh;
        sh = hdr << {idx, 3'b000};
        return sh[159:152];
    endfunction

endpackage

// File: rtl/udp_send_crc32_d8.sv
// Byte-wide reflected CRC-32 (Ethernet FCS); crc_out is the raw register,
// the caller applies the final inversion.
module crc32_d8
    import udp_send_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        crc_clr,
    input  logic        crc_en,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_d;
    logic [31:0] crc_q;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // Next CRC value: clear, accumulate one byte, or hold.
    always_comb begin
        crc_d = crc_q;
        if (crc_clr) begin
            crc_d = CRC32_INIT;
        end else if (crc_en) begin
            crc_d = crc_next(crc_q, data_in);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/udp_send.sv
// GMII IPv4/UDP frame transmitter. Optional short-frame padding to the
// 64-byte Ethernet minimum is enabled by defining UDP_TX_PAD_EN.
module udp_send
    import udp_send_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd123},
    parameter logic [47:0] DES_MAC    = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] DES_IP     = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter logic [15:0] SRC_PORT   = 16'h5000,
    parameter logic [15:0] DES_PORT   = 16'h6000,
    parameter logic [15:0] IFG_CYCLES = 16'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [15:0] tx_byte_num,
    output logic        tx_req,
    input  logic [7:0]  tx_data,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        eth_txen,
    output logic [7:0]  eth_txd
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] ip_id_q, ip_id_d;
    logic [31:0] cks_q, cks_d;
    logic        txen_q, txen_d;
    logic [7:0]  txd_q, txd_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        crc_clr;
    logic        crc_en;
    logic [31:0] crc_out;

    logic [15:0]  total_len_s;
    logic [15:0]  udp_len_s;
    logic [15:0]  data_len_s;
    logic [31:0]  ip_sum_s;
    logic [159:0] eth_hdr_s;
    logic [159:0] ip_hdr_s;
    logic [159:0] udp_hdr_s;

    assign total_len_s = len_q + 16'd28;
    assign udp_len_s   = len_q + 16'd8;

`ifdef UDP_TX_PAD_EN
    localparam logic [15:0] MIN_PAYLOAD = 16'd18;
    // Pad bytes extend TX_DATA only; the length fields keep the real N.
    assign data_len_s = (len_q < MIN_PAYLOAD) ? MIN_PAYLOAD : len_q;
`else
    assign data_len_s = len_q;
`endif

    assign eth_hdr_s = {DES_MAC, BOARD_MAC, ETHERTYPE_IPV4, 48'h0};
    assign ip_hdr_s  = {8'h45, 8'h00, total_len_s, ip_id_q, 16'h4000,
                        IP_TTL, IP_PROTO_UDP, cks_q[15:0], BOARD_IP, DES_IP};
    assign udp_hdr_s = {SRC_PORT, DES_PORT, udp_len_s, 16'h0000, 96'h0};

    // Header words with the checksum field taken as zero.
    assign ip_sum_s = 32'h0000_4500 + {16'd0, total_len_s} + {16'd0, ip_id_q}
                    + 32'h0000_4000 + {16'd0, IP_TTL, IP_PROTO_UDP}
                    + {16'd0, BOARD_IP[31:16]} + {16'd0, BOARD_IP[15:0]}
                    + {16'd0, DES_IP[31:16]} + {16'd0, DES_IP[15:0]};

    crc32_d8 u_crc (
        .clk     (clk),
        .rst     (rst),
        .crc_clr (crc_clr),
        .crc_en  (crc_en),
        .data_in (txd_d),
        .crc_out (crc_out)
    );

    // Frame sequencer: next state, counters and the byte to drive next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        len_d   = len_q;
        ip_id_d = ip_id_q;
        cks_d   = cks_q;
        txen_d  = 1'b0;
        txd_d   = 8'h00;
        req_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = 16'd0;
                crc_clr = 1'b1;
                busy_d  = 1'b0;
                if (tx_start && !busy_q && (tx_byte_num != 16'd0)) begin
                    state_d = ST_CHECK_SUM;
                    busy_d  = 1'b1;
                    len_d   = (tx_byte_num > MAX_PAYLOAD) ? MAX_PAYLOAD : tx_byte_num;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK_SUM: begin
                // Sum, fold, fold again, invert.
                case (cnt_q[1:0])
                    2'd0:    cks_d = ip_sum_s;
                    2'd1:    cks_d = {15'd0, {1'b0, cks_q[15:0]} + {1'b0, cks_q[31:16]}};
                    2'd2:    cks_d = {15'd0, {1'b0, cks_q[15:0]} + {16'd0, cks_q[16]}};
                    2'd3:    cks_d = {16'd0, ~cks_q[15:0]};
                    default: cks_d = cks_q;
                endcase
                if (cnt_q == CHECK_SUM_LEN - 16'd1) begin
                    state_d = ST_PREAMBLE;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_CHECK_SUM;
                end
            end
            ST_PREAMBLE: begin
                txen_d = 1'b1;
                if (cnt_q == PREAMBLE_LEN - 16'd1) begin
                    txd_d   = SFD_BYTE;
                    state_d = ST_ETH_HEAD;
                    cnt_d   = 16'd0;
                end else begin
                    txd_d   = PREAMBLE_BYTE;
                end
            end
            ST_ETH_HEAD: begin
                txen_d = 1'b1;
                crc_en = 1'b1;
                txd_d  = hdr_byte(eth_hdr_s, cnt_q[4:0]);
                if (cnt_q == ETH_HEAD_LEN - 16'd1) begin
                    state_d = ST_IP_HEAD;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_ETH_HEAD;
                end
            end
            ST_IP_HEAD: begin
                txen_d = 1'b1;
                crc_en = 1'b1;
                txd_d  = hdr_byte(ip_hdr_s, cnt_q[4:0]);
                if (cnt_q == IP_HEAD_LEN - 16'd1) begin
                    state_d = ST_UDP_HEAD;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_IP_HEAD;
                end
            end
            ST_UDP_HEAD: begin
                txen_d = 1'b1;
                crc_en = 1'b1;
                txd_d  = hdr_byte(udp_hdr_s, cnt_q[4:0]);
                // Requests run two cycles ahead of the byte they fetch.
                req_d  = (cnt_q >= 16'd6) && ((cnt_q - 16'd6) < len_q);
                if (cnt_q == UDP_HEAD_LEN - 16'd1) begin
                    state_d = ST_TX_DATA;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_UDP_HEAD;
                end
            end
            ST_TX_DATA: begin
                txen_d = 1'b1;
                crc_en = 1'b1;
                txd_d  = (cnt_q < len_q) ? tx_data : 8'h00;
                req_d  = (cnt_q + 16'd2) < len_q;
                if (cnt_q == data_len_s - 16'd1) begin
                    state_d = ST_CRC;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_TX_DATA;
                end
            end
            ST_CRC: begin
                txen_d = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    txd_d = ~crc_out[7:0];
                    2'd1:    txd_d = ~crc_out[15:8];
                    2'd2:    txd_d = ~crc_out[23:16];
                    2'd3:    txd_d = ~crc_out[31:24];
                    default: txd_d = 8'h00;
                endcase
                if (cnt_q == CRC_LEN - 16'd1) begin
                    state_d = ST_IFG;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_CRC;
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_CYCLES - 16'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ip_id_d = ip_id_q + 16'd1;
                end else begin
                    state_d = ST_IFG;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            len_q   <= 16'd0;
            ip_id_q <= 16'd0;
            cks_q   <= 32'd0;
            txen_q  <= 1'b0;
            txd_q   <= 8'h00;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ip_id_q <= ip_id_d;
            cks_q   <= cks_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign eth_txen = txen_q;
    assign eth_txd  = txd_q;
    assign tx_req   = req_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
